counter_n_bits_ctl: RTL and testbench



---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_next_val.sv | 41 ++++
 rtl/counter_n_bits_ctl.sv | 75 +++++++
 tb/tb_counter_n_bits_ctl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode and direction constants for the n-bit control counter.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/counter_next_val.sv
// Combinational step logic: next count for one enabled step, plus bound_hit when a bound is crossed or blocked.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_dn_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bound_hit_o
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam bit               SAT   = (SATURATE == CNT_SAT);

    always_comb begin
        next_o      = count_i;
        bound_hit_o = 1'b0;
        if (en_i) begin
            if (up_dn_i == CNT_UP) begin
                if (count_i == MAX_W) begin
                    bound_hit_o = 1'b1;
                    next_o      = SAT ? count_i : '0;
                end else begin
                    next_o = count_i + WIDTH'(1);
                end
            end else begin
                if (count_i == '0) begin
                    bound_hit_o = 1'b1;
                    next_o      = SAT ? count_i : MAX_W;
                end else begin
                    next_o = count_i - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/counter_n_bits_ctl.sv
// Up/down counter with clear, clamped load, programmable modulus, wrap/saturate mode,
// combinational terminal count and a registered bound-event pulse.
module counter_n_bits_ctl
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_val;
    logic             bound_hit;
    logic [WIDTH-1:0] load_clamped;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i     (count_q),
        .up_dn_i     (up_dn),
        .en_i        (en),
        .next_o      (step_val),
        .bound_hit_o (bound_hit)
    );

    // Clamp only exists when the modulus leaves unreachable codes above MAX_VAL.
    if (MAX_VAL < 2**WIDTH-1) begin : g_clamp
        assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    end else begin : g_noclamp
        assign load_clamped = load_val;
    end

    always_comb begin
        count_d = step_val;
        ovf_d   = bound_hit;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = (up_dn == CNT_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_counter_n_bits_ctl.sv
// Scoreboard bench driving three counter configurations (wrap, saturate, 1-bit) with shared stimulus.
module tb_counter_n_bits_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1;
    logic [3:0] load_val = '0;
    logic [0:0] load_val1;

    logic [3:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;
    logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    assign load_val1 = load_val[0];

    always #5 clk = ~clk;

    counter_n_bits_ctl #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));

    counter_n_bits_ctl #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));

    counter_n_bits_ctl #(.WIDTH(1), .MAX_VAL(1), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val1),
        .en(en), .up_dn(up_dn), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

    typedef struct {
        int a_cnt; bit a_ovf;
        int b_cnt; bit b_ovf;
        int c_cnt; bit c_ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ma = 0, mb = 0, mc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input int cnt, input int maxv, input bit sat,
                                       input bit r, input bit c, input bit l, input int lv,
                                       input bit e, input bit ud,
                                       output int ncnt, output bit novf);
        ncnt = cnt;
        novf = 1'b0;
        if (r || c) begin
            ncnt = 0;
        end else if (l) begin
            ncnt = (lv > maxv) ? maxv : lv;
        end else if (e) begin
            if (ud) begin
                if (cnt < maxv) ncnt = cnt + 1;
                else begin ncnt = sat ? cnt : 0; novf = 1'b1; end
            end else begin
                if (cnt > 0) ncnt = cnt - 1;
                else begin ncnt = sat ? cnt : maxv; novf = 1'b1; end
            end
        end
    endfunction

    function automatic bit model_tc(input int cnt, input int maxv, input bit ud);
        return ud ? (cnt == maxv) : (cnt == 0);
    endfunction

    task automatic check_tc(input string tag);
        check_val({tag, ".tc_a"}, {31'd0, tc_a}, {31'd0, model_tc(ma, 9, up_dn)});
        check_val({tag, ".tc_b"}, {31'd0, tc_b}, {31'd0, model_tc(mb, 9, up_dn)});
        check_val({tag, ".tc_c"}, {31'd0, tc_c}, {31'd0, model_tc(mc, 1, up_dn)});
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
    task automatic cycle(input string tag, input bit r, input bit c, input bit l,
                         input int lv, input bit e, input bit ud);
        exp_t x;
        exp_t got;
        rst = r; clear = c; load = l; load_val = lv[3:0]; en = e; up_dn = ud;
        model_step(ma, 9, 1'b0, r, c, l, lv,     e, ud, x.a_cnt, x.a_ovf);
        model_step(mb, 9, 1'b1, r, c, l, lv,     e, ud, x.b_cnt, x.b_ovf);
        model_step(mc, 1, 1'b0, r, c, l, lv & 1, e, ud, x.c_cnt, x.c_ovf);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_val({tag, ".cnt_a"}, {28'd0, cnt_a}, got.a_cnt);
        check_val({tag, ".ovf_a"}, {31'd0, ovf_a}, {31'd0, got.a_ovf});
        check_val({tag, ".cnt_b"}, {28'd0, cnt_b}, got.b_cnt);
        check_val({tag, ".ovf_b"}, {31'd0, ovf_b}, {31'd0, got.b_ovf});
        check_val({tag, ".cnt_c"}, {31'd0, cnt_c}, got.c_cnt);
        check_val({tag, ".ovf_c"}, {31'd0, ovf_c}, {31'd0, got.c_ovf});
        ma = got.a_cnt; mb = got.b_cnt; mc = got.c_cnt;
        check_tc(tag);
    endtask

    int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn[5]  = '{2, 1, 0, 9, 8};

    initial begin
        // Reset with every other control active: outputs must still settle to 0.
        cycle("reset", 1, 1, 1, 7, 1, 1);
        check_val("reset.cnt_a_const", {28'd0, cnt_a}, 0);
        check_val("reset.tc_a_const", {31'd0, tc_a}, 0);

        for (int i = 0; i < 12; i++) begin
            cycle("wrap_up", 0, 0, 0, 0, 1, 1);
            check_val("wrap_up.table", {28'd0, cnt_a}, exp_up[i]);
            check_val("wrap_up.ovf_table", {31'd0, ovf_a}, {31'd0, (i == 9)});
        end

        cycle("load3", 0, 0, 1, 3, 0, 0);
        check_val("load3.table", {28'd0, cnt_a}, 3);
        for (int i = 0; i < 5; i++) begin
            cycle("wrap_dn", 0, 0, 0, 0, 1, 0);
            check_val("wrap_dn.table", {28'd0, cnt_a}, exp_dn[i]);
            check_val("wrap_dn.ovf_table", {31'd0, ovf_a}, {31'd0, (i == 3)});
        end

        cycle("load8", 0, 0, 1, 8, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle("sat_up", 0, 0, 0, 0, 1, 1);
            check_val("sat_up.table", {28'd0, cnt_b}, 9);
            check_val("sat_up.ovf_table", {31'd0, ovf_b}, {31'd0, (i >= 1)});
        end
        cycle("sat_dn", 0, 0, 0, 0, 1, 0);
        check_val("sat_dn.table", {28'd0, cnt_b}, 8);

        cycle("load5", 0, 0, 1, 5, 0, 1);
        cycle("clr_ld_en", 0, 1, 1, 7, 1, 1);
        check_val("clr_ld_en.table", {28'd0, cnt_a}, 0);
        cycle("ld_en", 0, 0, 1, 7, 1, 1);
        check_val("ld_en.table", {28'd0, cnt_a}, 7);

        cycle("clamp", 0, 0, 1, 15, 0, 1);
        check_val("clamp.table", {28'd0, cnt_a}, 9);
        cycle("pre_rst", 0, 0, 0, 0, 1, 0);
        cycle("pre_rst", 0, 0, 0, 0, 1, 0);
        cycle("rst_mid", 1, 0, 0, 0, 1, 1);
        check_val("rst_mid.table", {28'd0, cnt_a}, 0);
        for (int i = 0; i < 3; i++) cycle("resume", 0, 0, 0, 0, 1, 1);
        check_val("resume.table", {28'd0, cnt_a}, 3);

        // tc must follow up_dn with no clock edge in between.
        cycle("tc_load", 0, 0, 1, 0, 0, 1);
        up_dn = 1'b0;
        #1;
        check_tc("tc_dn_comb");
        up_dn = 1'b1;
        #1;
        check_tc("tc_up_comb");

        for (int i = 0; i < 300; i++) begin
            cycle("rand",
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
